// File: rtl/grid_pkg.sv
// Shared playfield geometry and line-clear controller state encoding.
package grid_pkg;

   localparam int ROWS = 20;
   localparam int COLS = 10;
   localparam int XW   = 4;
   localparam int YW   = 5;

   localparam logic [XW-1:0] COL_LAST  = XW'(COLS - 1);
   localparam logic [YW-1:0] ROW_LAST  = YW'(ROWS - 1);
   localparam logic [YW-1:0] LINES_MAX = YW'(ROWS);

   typedef enum logic [2:0] {
      IDLE,
      SCAN,
      SHIFT_RD,
      SHIFT_WR,
      CLEAR_TOP,
      DONE
   } state_t;

endpackage

// File: rtl/grid.sv
// 20x10 playfield bit grid: combinational read gated by rd, registered write,
// cleared by the shared asynchronous reset.
module grid
   import grid_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic [XW-1:0] x,
   input  logic [YW-1:0] y,
   input  logic          rd,
   input  logic          wr,
   input  logic          din,
   output logic          dout
);

   logic [COLS-1:0] cells [ROWS];
   logic            in_range;

   assign in_range = (x < XW'(COLS)) && (y < YW'(ROWS));
   assign dout     = rd && in_range && cells[y][x];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < ROWS; r++) begin
            cells[r] <= '0;
         end
      end else if (wr && in_range) begin
         cells[y][x] <= din;
      end
   end

endmodule

// File: rtl/grid_line_clear_ctrl.sv
// Grid owner/arbiter: passes the host through when idle, otherwise scans the
// playfield bottom-up, collapses full lines and counts them.
//
// state     | meaning
// IDLE      | host passthrough, waiting for start
// SCAN      | read cell (col,row); first empty cell moves to the row above
// SHIFT_RD  | read cell (col,dst-1) into latch
// SHIFT_WR  | write latch into cell (col,dst)
// CLEAR_TOP | zero row 0, one column per cycle, then rescan same row
// DONE      | one-cycle done pulse
module grid_line_clear_ctrl
   import grid_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   output logic          busy,
   output logic          done,
   output logic [YW-1:0] lines_cleared,
   input  logic          host_req,
   output logic          host_gnt,
   input  logic [XW-1:0] host_x,
   input  logic [YW-1:0] host_y,
   input  logic          host_rd,
   input  logic          host_wr,
   input  logic          host_din,
   output logic          host_dout,
   output logic [XW-1:0] g_x,
   output logic [YW-1:0] g_y,
   output logic          g_rd,
   output logic          g_wr,
   output logic          g_din,
   input  logic          g_dout
);

   state_t        state_q, state_d;
   logic [YW-1:0] row_q, row_d;
   logic [XW-1:0] col_q, col_d;
   logic [YW-1:0] dst_q, dst_d;
   logic [YW-1:0] lines_q, lines_d;
   logic          latch_q, latch_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         row_q   <= '0;
         col_q   <= '0;
         dst_q   <= '0;
         lines_q <= '0;
         latch_q <= 1'b0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         col_q   <= col_d;
         dst_q   <= dst_d;
         lines_q <= lines_d;
         latch_q <= latch_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      row_d     = row_q;
      col_d     = col_q;
      dst_d     = dst_q;
      lines_d   = lines_q;
      latch_d   = latch_q;
      busy      = 1'b0;
      done      = 1'b0;
      host_gnt  = 1'b0;
      host_dout = 1'b0;
      g_x       = '0;
      g_y       = '0;
      g_rd      = 1'b0;
      g_wr      = 1'b0;
      g_din     = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               lines_d = '0;
               row_d   = ROW_LAST;
               col_d   = '0;
               state_d = SCAN;
            end else if (host_req) begin
               host_gnt  = 1'b1;
               g_x       = host_x;
               g_y       = host_y;
               g_rd      = host_rd;
               g_wr      = host_wr;
               g_din     = host_din;
               host_dout = g_dout;
            end
         end

         SCAN: begin
            busy = 1'b1;
            g_x  = col_q;
            g_y  = row_q;
            g_rd = 1'b1;
            if (!g_dout) begin
               col_d = '0;
               if (row_q == '0) begin
                  state_d = DONE;
               end else begin
                  row_d = row_q - YW'(1);
               end
            end else if (col_q != COL_LAST) begin
               col_d = col_q + XW'(1);
            end else begin
               if (lines_q != LINES_MAX) begin
                  lines_d = lines_q + YW'(1);
               end
               col_d = '0;
               if (row_q == '0) begin
                  state_d = CLEAR_TOP;
               end else begin
                  dst_d   = row_q;
                  state_d = SHIFT_RD;
               end
            end
         end

         SHIFT_RD: begin
            busy    = 1'b1;
            g_x     = col_q;
            g_y     = dst_q - YW'(1);
            g_rd    = 1'b1;
            latch_d = g_dout;
            state_d = SHIFT_WR;
         end

         SHIFT_WR: begin
            busy  = 1'b1;
            g_x   = col_q;
            g_y   = dst_q;
            g_wr  = 1'b1;
            g_din = latch_q;
            if (col_q != COL_LAST) begin
               col_d   = col_q + XW'(1);
               state_d = SHIFT_RD;
            end else begin
               col_d = '0;
               if (dst_q == YW'(1)) begin
                  state_d = CLEAR_TOP;
               end else begin
                  dst_d   = dst_q - YW'(1);
                  state_d = SHIFT_RD;
               end
            end
         end

         CLEAR_TOP: begin
            busy = 1'b1;
            g_x  = col_q;
            g_y  = '0;
            g_wr = 1'b1;
            if (col_q == COL_LAST) begin
               // row keeps its value: the row just shifted into it needs a rescan
               col_d   = '0;
               state_d = SCAN;
            end else begin
               col_d = col_q + XW'(1);
            end
         end

         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

   assign lines_cleared = lines_q;

endmodule

// File: doc/grid_line_clear_ctrl.md
Name: grid_line_clear_ctrl

Overview:
Controller and arbiter in front of the 20x10 playfield grid (single shared x/y address, combinational read, registered write). When idle it passes a host requester (piece placer / renderer) straight through to the grid. On start it takes ownership of the grid, scans rows bottom-up for full lines, shifts everything above each full line down by one row, clears row 0, and reports the number of lines removed.

Parameters:
ROWS, 20, number of grid rows; y=0 is the top row, y=ROWS-1 is the bottom row
COLS, 10, number of grid columns
XW, 4, column address width
YW, 5, row address width

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
start  input  1  request a line-clear pass; sampled only in IDLE
busy  output  1  high while the controller owns the grid (SCAN..CLEAR_TOP)
done  output  1  single-cycle pulse at the end of a pass
lines_cleared  output  YW  full rows removed in the last pass; held until the next accepted start
host_req  input  1  host wants grid access this cycle
host_gnt  output  1  host access granted this cycle (combinational)
host_x  input  XW  host column
host_y  input  YW  host row
host_rd  input  1  host read enable
host_wr  input  1  host write enable
host_din  input  1  host write data
host_dout  output  1  grid read data returned to host; 0 when not granted
g_x  output  XW  grid column address
g_y  output  YW  grid row address
g_rd  output  1  grid read enable
g_wr  output  1  grid write enable
g_din  output  1  grid write data
g_dout  input  1  grid read data (combinational from g_x/g_y)

Behaviour:
- Reset: state IDLE; busy=0, done=0, lines_cleared=0, host_gnt=0, g_rd=g_wr=g_din=0, g_x=g_y=0; internal row/col/dst/latch registers = 0.
- Arbitration: host_gnt = (state==IDLE) && host_req && !start. While granted, g_* = host_* and host_dout = g_dout. Otherwise host_dout=0 and host strobes are ignored (never queued). start beats host_req in the same cycle.
- IDLE: start=1 -> lines_cleared<=0, row<=ROWS-1, col<=0, next SCAN.
- SCAN: g_x=col, g_y=row, g_rd=1.
  - g_dout==0: if row==0 -> DONE; else row<=row-1, col<=0 (early exit on the first empty cell).
  - g_dout==1 and col<COLS-1: col<=col+1.
  - g_dout==1 and col==COLS-1: full row. lines_cleared<=lines_cleared+1, col<=0. If row==0 -> CLEAR_TOP; else dst<=row, next SHIFT_RD.
- SHIFT_RD: g_x=col, g_y=dst-1, g_rd=1; latch<=g_dout; next SHIFT_WR.
- SHIFT_WR: g_x=col, g_y=dst, g_wr=1, g_din=latch.
  - col<COLS-1: col<=col+1, next SHIFT_RD.
  - col==COLS-1: col<=0. If dst==1 -> CLEAR_TOP; else dst<=dst-1, next SHIFT_RD.
- CLEAR_TOP: g_x=col, g_y=0, g_wr=1, g_din=0. When col==COLS-1: col<=0, next SCAN at the unchanged row, because the row shifted into it must be rescanned.
- DONE: done=1 for one cycle, busy=0, next IDLE.
- Timing: 1 cycle per scanned cell, 2 cycles per shifted cell (20 per row), 10 cycles for the top clear.
- Arithmetic: lines_cleared saturates at ROWS (it cannot exceed ROWS).
- start while busy: ignored.
- rst mid-pass: immediate return to IDLE with reset values. The grid shares rst, so it is also cleared.
- In non-IDLE states, any g_rd/g_wr not listed above is 0.

Decomposition:
- Package grid_pkg holds ROWS, COLS, XW, YW and the state enum {IDLE, SCAN, SHIFT_RD, SHIFT_WR, CLEAR_TOP, DONE}. The grid module is reworked to import it.
- No sub-module: a single FSM plus counters. The grid is instantiated beside it at the top level.

Test Plan:
- Empty grid, start pulse -> 20 SCAN cycles (col 0 of each row only), done pulse 21 cycles after start is sampled, lines_cleared=0, no g_wr ever asserted.
- Row 19 full, row 18 = cells 0,1 set -> lines_cleared=1; afterwards row 19 = cells 0,1 set, rows 0..18 empty, row 0 cleared.
- Rows 16..19 full, row 15 = cell 9 set -> lines_cleared=4; row 19 = cell 9 only, all other cells 0.
- Row 19 full, row 18 empty, row 17 full -> lines_cleared=2 (rows not contiguous); row 19 = old row 18 contents (empty); every other row empty.
- host_req=1 with start=1 in the same IDLE cycle -> host_gnt=0, controller enters SCAN; host_wr during busy leaves the grid unchanged; host_gnt=1 the cycle after done.
- Assert rst during SHIFT_WR -> next cycle state IDLE, busy=0, done=0, lines_cleared=0, grid reads all 0.
